div_enable_sched: RTL and testbench



---
 rtl/div_enable_sched.sv | 139 +++++++++++++
 tb/tb_div_enable_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_enable_sched.sv
// Programmable clock-enable scheduler: prescaled tick routed round-robin to masked channels,
// with idle-only config loading and start/stop/done burst sequencing.
module div_enable_sched #(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  parameter  int CNTW  = 8,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [NCH-1:0]   cfg_mask,
  input  logic [CNTW-1:0]  cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic [NCH-1:0]   en,
  output logic [CHW-1:0]   ch_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] div_reg, div_n, cnt, cnt_n;
  logic [NCH-1:0]   mask_reg, mask_n;
  logic [CNTW-1:0]  count_reg, count_n, ticks, ticks_n, ticks_inc;
  logic [CHW-1:0]   ch_n;

  function automatic logic [CHW-1:0] lowest_set(input logic [NCH-1:0] m);
    lowest_set = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = CHW'(i);
      else      lowest_set = lowest_set;
    end
  endfunction

  // Next set bit strictly above cur, wrapping; a single-bit mask returns cur itself.
  function automatic logic [CHW-1:0] next_set(input logic [NCH-1:0] m, input logic [CHW-1:0] cur);
    logic found;
    int   idx;
    next_set = cur;
    found    = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(cur) + i) % NCH;
      if (!found && m[idx]) begin
        next_set = CHW'(idx);
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  assign tick      = (state == RUN) && (cnt == '0);
  assign en        = tick ? ({{(NCH-1){1'b0}}, 1'b1} << ch_idx) : '0;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign cfg_ready = (state == IDLE);
  assign ticks_inc = ticks + CNTW'(1);

  // Next-state and datapath update.
  always_comb begin
    state_n = state;
    div_n   = div_reg;
    mask_n  = mask_reg;
    count_n = count_reg;
    cnt_n   = cnt;
    ticks_n = ticks;
    ch_n    = ch_idx;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          div_n   = cfg_div;
          mask_n  = cfg_mask;
          count_n = cfg_count;
        end else begin
          div_n = div_reg;
        end
        // Start decisions use the registers as they stand, not a same-cycle config.
        if (start && !stop && (mask_reg != '0)) begin
          state_n = RUN;
          cnt_n   = div_reg;
          ticks_n = '0;
          ch_n    = lowest_set(mask_reg);
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          cnt_n   = '0;
          ticks_n = '0;
        end else if (cnt != '0) begin
          cnt_n = cnt - WIDTH'(1);
        end else begin
          cnt_n   = div_reg;
          ticks_n = ticks_inc;
          ch_n    = next_set(mask_reg, ch_idx);
          if ((count_reg != '0) && (ticks_inc == count_reg)) begin
            state_n = DONE;
            cnt_n   = '0;
            ticks_n = '0;
          end else begin
            state_n = RUN;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      div_reg   <= WIDTH'(2);
      mask_reg  <= '1;
      count_reg <= '0;
      cnt       <= '0;
      ticks     <= '0;
      ch_idx    <= '0;
    end else begin
      state     <= state_n;
      div_reg   <= div_n;
      mask_reg  <= mask_n;
      count_reg <= count_n;
      cnt       <= cnt_n;
      ticks     <= ticks_n;
      ch_idx    <= ch_n;
    end
  end

endmodule

// File: tb/tb_div_enable_sched.sv
// Scoreboard bench for div_enable_sched: expected ticks (cycle, enable, channel) are queued
// when a run is started and compared as the DUT presents each tick.
`timescale 1ns/1ps
module tb_div_enable_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_div = 8'd0;
  logic [3:0] cfg_mask = 4'd0;
  logic [7:0] cfg_count = 8'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       tick;
  logic [3:0] en;
  logic [1:0] ch_idx;
  logic       busy;
  logic       done;

  typedef struct {
    int         cyc;
    logic [3:0] en;
    int         ch;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_seen = 0;

  div_enable_sched #(.WIDTH(8), .NCH(4), .CNTW(8)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_mask(cfg_mask), .cfg_count(cfg_count),
    .start(start), .stop(stop), .tick(tick), .en(en), .ch_idx(ch_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Tick monitor: every presented tick must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_seen++;
      if (tick) begin
        if (q.size() == 0) begin
          check("unexpected_tick", 32'(tick), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("tick_cycle", 32'(cyc), 32'(e.cyc));
          check("tick_en", 32'(en), 32'(e.en));
          check("tick_ch", 32'(ch_idx), 32'(e.ch));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_cfg(input int div, input logic [3:0] mask, input int count);
    cfg_valid = 1'b1;
    cfg_div   = 8'(div);
    cfg_mask  = mask;
    cfg_count = 8'(count);
    step(1);
    cfg_valid = 1'b0;
  endtask

  // Queue the expected ticks of a run, then pulse start.
  task automatic start_run(input int div, input logic [3:0] mask, input int nticks);
    int c;
    int ch;
    c  = cyc;
    ch = 0;
    while (!mask[ch]) ch++;
    for (int k = 0; k < nticks; k++) begin
      exp_t e;
      e.cyc = c + 1 + div + k * (div + 1);
      e.en  = 4'b0001 << ch;
      e.ch  = ch;
      q.push_back(e);
      for (int s = 1; s <= 4; s++) begin
        if (mask[(ch + s) % 4]) begin
          ch = (ch + s) % 4;
          break;
        end
      end
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) step(1);
    check(tag, 32'(q.size()), 32'd0);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_en", 32'(en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ch", 32'(ch_idx), 32'd0);
    step(2);
    reset = 1'b0;
    step(1);

    // Defaults: period 3, full rotation, free-running.
    start_run(2, 4'b1111, 5);
    check("def_busy", 32'(busy), 32'd1);
    wait_drain("def_drain", 40);
    do_stop();
    check("def_stop_busy", 32'(busy), 32'd0);
    check("def_no_done", 32'(done_seen), 32'd0);

    // div=0: tick every cycle, channels 0 and 2 alternate.
    do_cfg(0, 4'b0101, 0);
    start_run(0, 4'b0101, 6);
    wait_drain("div0_drain", 20);
    do_stop();
    check("div0_stop_tick", 32'(tick), 32'd0);

    // Three-tick burst on a single channel, then one-cycle done.
    do_cfg(1, 4'b1000, 3);
    start_run(1, 4'b1000, 3);
    wait_drain("burst_drain", 20);
    step(1);
    check("burst_done", 32'(done), 32'd1);
    check("burst_done_busy", 32'(busy), 32'd0);
    check("burst_done_ready", 32'(cfg_ready), 32'd0);
    step(1);
    check("burst_done_end", 32'(done), 32'd0);
    check("burst_idle_ready", 32'(cfg_ready), 32'd1);
    check("burst_idle_busy", 32'(busy), 32'd0);
    check("burst_done_count", 32'(done_seen), 32'd1);

    // Stop while counting down: no tick, idle at once.
    do_cfg(5, 4'b1111, 0);
    start_run(5, 4'b1111, 0);
    step(2);
    check("stop_pre_busy", 32'(busy), 32'd1);
    do_stop();
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_tick", 32'(tick), 32'd0);
    step(8);
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy", 32'(busy), 32'd0);
    check("startstop_tick", 32'(tick), 32'd0);

    // Config offered mid-run is refused and the period is unchanged.
    start_run(5, 4'b1111, 2);
    cfg_valid = 1'b1;
    cfg_div   = 8'd7;
    check("run_cfg_ready", 32'(cfg_ready), 32'd0);
    step(1);
    check("run_cfg_ready2", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    wait_drain("run_cfg_drain", 30);
    do_stop();

    // Empty mask blocks start; a same-cycle config does not rescue it.
    do_cfg(2, 4'b0000, 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("mask0_busy", 32'(busy), 32'd0);
    check("mask0_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_mask  = 4'b0011;
    start     = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    start     = 1'b0;
    check("samecyc_busy", 32'(busy), 32'd0);
    step(4);

    // Asynchronous reset mid-run, between clock edges.
    do_cfg(0, 4'b0010, 0);
    start_run(0, 4'b0010, 3);
    wait_drain("pre_rst_drain", 10);
    check("pre_rst_tick", 32'(tick), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_tick", 32'(tick), 32'd0);
    check("arst_en", 32'(en), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(cfg_ready), 32'd1);
    check("arst_ch", 32'(ch_idx), 32'd0);
    step(2);
    reset = 1'b0;
    step(1);
    start_run(2, 4'b1111, 4);
    wait_drain("post_rst_drain", 30);
    do_stop();
    step(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
